// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types and constants
package rf_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [REG_COUNT-1:0] idx_onehot(input reg_idx_t idx);
    logic [REG_COUNT-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with combinational grant
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  // ptr names the requester that wins when both ask; grants are held off in reset
  always_comb begin
    grant    = 2'b00;
    grant[0] = reset & req[0] & (~req[1] | ~ptr);
    grant[1] = reset & req[1] & (~req[0] |  ptr);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - write-port arbiter, registered write stage and RAW scoreboard
module regfile_wb_scheduler
  import rf_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            mark_valid,
  input  reg_idx_t        mark_rd,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic            stall_rs1,
  output logic            stall_rs2,
  input  logic            wb0_valid,
  input  reg_idx_t        wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  input  reg_idx_t        wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb0_ready,
  output logic            wb1_ready,
  input  logic            flush,
  output logic            sb_error,
  output logic            rf_write,
  output reg_idx_t        rf_rd,
  output logic [XLEN-1:0] rf_writedata
);

  wb_req_t              req0, req1, sel;
  logic [1:0]           grant;
  logic                 accept;
  logic [REG_COUNT-1:0] pending, pending_next, set_mask, clear_mask;
  logic                 error_hit;

  assign req0 = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
  assign req1 = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({req1.valid, req0.valid}),
    .grant (grant)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];

  // x0 handshakes complete but never reach the register file
  always_comb begin
    sel    = grant[1] ? req1 : req0;
    accept = (|grant) && (sel.rd != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_write     <= 1'b0;
      rf_rd        <= '0;
      rf_writedata <= '0;
    end else begin
      rf_write <= accept;
      if (accept) begin
        rf_rd        <= sel.rd;
        rf_writedata <= sel.data;
      end
    end
  end

  // clear lands with the register-file write; a same-edge mark or a flush-time mark still sticks
  always_comb begin
    clear_mask      = rf_write ? idx_onehot(rf_rd) : '0;
    set_mask        = (mark_valid && mark_rd != '0) ? idx_onehot(mark_rd) : '0;
    pending_next    = flush ? '0 : (pending & ~clear_mask);
    pending_next    = pending_next | set_mask;
    pending_next[0] = 1'b0;
    error_hit       = |(set_mask & pending & ~clear_mask);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending  <= '0;
      sb_error <= 1'b0;
    end else begin
      pending <= pending_next;
      if (error_hit) begin
        sb_error <= 1'b1;
      end
    end
  end

  assign stall_rs1 = (rs1 != '0) && pending[rs1];
  assign stall_rs2 = (rs2 != '0) && pending[rs2];

endmodule
